// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit placed between ID and EX of the RISC core. Every in-flight
// register write is tracked by a per-register countdown counter that holds
// the number of cycles still needed before the result can be forwarded. While
// an ID source operand is still counting down, IF/ID are held and a bubble is
// injected into EX. A taken branch/jump resolved in EX squashes IF and ID and
// takes priority over any stall. A saturating counter records stall cycles.
//
// Ports:
//   clk                        clock, all state on the rising edge
//   rst_n                      synchronous active-low reset
//   id_valid                   ID holds a valid instruction
//   id_rs1, id_rs2             ID source register indices
//   id_rs1_used, id_rs2_used   the corresponding source is actually read
//   id_rd                      ID destination register
//   id_reg_write               the ID instruction writes id_rd
//   id_is_load                 the ID instruction is a load
//   ex_flush                   taken branch/jump resolved in EX
//   stall_IF, stall_ID         hold PC and the IF/ID register
//   bubble_EX                  inject a NOP into ID/EX
//   flush_IF, flush_ID         squash IF and ID contents
//   busy_mask                  bit r set while register r has a pending count
//   stall_count                saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_W        = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int ALU_LATENCY  = 0,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic                ex_flush,
  output logic                stall_IF,
  output logic                stall_ID,
  output logic                bubble_EX,
  output logic                flush_IF,
  output logic                flush_ID,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int MAX_LAT = (LOAD_LATENCY > ALU_LATENCY) ? LOAD_LATENCY : ALU_LATENCY;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LATENCY);
  localparam logic [CW-1:0] ALU_L  = CW'(ALU_LATENCY);

  logic [CW-1:0]    cnt_q [NUM_REGS];
  logic [CW-1:0]    cnt_d [NUM_REGS];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic             haz;
  logic             stall;
  logic             issue;
  logic             wr_en;
  logic [CW-1:0]    wr_lat;

  // Looks the index up by comparison so an index outside 1..NUM_REGS-1
  // (x0 or an unimplemented register) simply reads as not busy.
  function automatic logic src_busy(input logic [REG_W-1:0]    idx,
                                    input logic [NUM_REGS-1:0] mask);
    src_busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (idx == REG_W'(r)) src_busy = mask[r];
    end
  endfunction

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    haz = id_valid & ((id_rs1_used & src_busy(id_rs1, busy_mask)) |
                      (id_rs2_used & src_busy(id_rs2, busy_mask)));
    // A flush squashes the ID instruction, so there is nothing to stall for.
    stall  = haz & ~ex_flush;
    issue  = id_valid & ~haz & ~ex_flush;
    wr_en  = issue & id_reg_write & (id_rd != '0);
    wr_lat = id_is_load ? LOAD_L : ALU_L;
  end

  assign stall_IF    = stall;
  assign stall_ID    = stall;
  assign bubble_EX   = stall;
  assign flush_IF    = ex_flush;
  assign flush_ID    = ex_flush;
  assign stall_count = stall_cnt_q;

  always_comb begin
    logic [CW-1:0] dec;
    dec = '0;
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      dec = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CW'(1);
      cnt_d[r] = dec;
      // Keep the longer of the pending and the new latency so a younger,
      // faster writer (WAW) never shortens an older writer's wait.
      if (wr_en && (id_rd == REG_W'(r)) && (wr_lat > dec)) begin
        cnt_d[r] = wr_lat;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_scoreboard. Three instances share one stimulus stream:
//   0: LOAD_LATENCY=1 ALU_LATENCY=0 CNT_W=16 (defaults)
//   1: LOAD_LATENCY=3 ALU_LATENCY=1 CNT_W=16
//   2: LOAD_LATENCY=3 ALU_LATENCY=0 CNT_W=4
// The reference model keeps, per register, the absolute cycle at which its
// value becomes forwardable; a register is busy while that cycle lies in the
// future. Expected outputs are queued by the stimulus and checked by a
// separate monitor.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, ex_flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  wire        a_sif [3];
  wire        a_sid [3];
  wire        a_bub [3];
  wire        a_fif [3];
  wire        a_fid [3];
  wire [31:0] a_bm  [3];
  wire [15:0] a_sc  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LL = (g == 0) ? 1 : 3;
    localparam int AL = (g == 1) ? 1 : 0;
    localparam int CW = (g == 2) ? 4 : 16;
    logic          sif, sid, bub, fif, fid;
    logic [31:0]   bm;
    logic [CW-1:0] sc;
    hazard_scoreboard #(
      .NUM_REGS(32), .REG_W(5), .LOAD_LATENCY(LL), .ALU_LATENCY(AL), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .ex_flush(ex_flush),
      .stall_IF(sif), .stall_ID(sid), .bubble_EX(bub),
      .flush_IF(fif), .flush_ID(fid),
      .busy_mask(bm), .stall_count(sc)
    );
    assign a_sif[g] = sif;
    assign a_sid[g] = sid;
    assign a_bub[g] = bub;
    assign a_fif[g] = fif;
    assign a_fid[g] = fid;
    assign a_bm[g]  = bm;
    assign a_sc[g]  = 16'(sc);
  end

  // Reference model
  int     lat_ld [3] = '{1, 3, 3};
  int     lat_alu[3] = '{0, 1, 0};
  int     sc_max [3] = '{65535, 65535, 15};
  longint ready  [3][32];
  int     scm    [3];
  longint cyc = 0;
  bit     push_en = 1'b0;

  typedef struct {
    int          k;
    longint      cyc;
    bit          stall;
    bit          flush;
    logic [31:0] bm;
    int          sc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int k, input longint c,
                     input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, c, act, exp);
    end
  endtask

  // One ID cycle: drive inputs at the falling edge, queue the expected
  // response for every instance, then advance the model past the next edge.
  task automatic step(input bit r_n, input bit v,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit ld, input bit fl);
    logic [31:0] bm;
    bit          haz, stl, iss;
    int          lat;
    exp_t        e;
    @(negedge clk);
    rst_n        = r_n;
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rs1_used  = u1;
    id_rs2_used  = u2;
    id_rd        = 5'(rd);
    id_reg_write = we;
    id_is_load   = ld;
    ex_flush     = fl;
    for (int k = 0; k < 3; k++) begin
      bm = '0;
      for (int r = 1; r < 32; r++) bm[r] = (ready[k][r] > cyc);
      haz = v && ((u1 && bm[rs1]) || (u2 && bm[rs2]));
      stl = haz && !fl;
      iss = v && !haz && !fl;
      e.k = k; e.cyc = cyc; e.stall = stl; e.flush = fl; e.bm = bm; e.sc = scm[k];
      if (push_en) q.push_back(e);
      if (!r_n) begin
        for (int r = 0; r < 32; r++) ready[k][r] = 0;
        scm[k] = 0;
      end else begin
        if (stl && scm[k] < sc_max[k]) scm[k]++;
        if (iss && we && rd != 0) begin
          lat = ld ? lat_ld[k] : lat_alu[k];
          if (cyc + 1 + lat > ready[k][rd]) ready[k][rd] = cyc + 1 + lat;
        end
      end
    end
    cyc++;
  endtask

  task automatic ins(input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit we, input bit ld, input bit fl);
    step(1'b1, 1'b1, rs1, u1, rs2, u2, rd, we, ld, fl);
  endtask

  task automatic nops(input int n);
    repeat (n) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_IF",    e.k, e.cyc, a_sif[e.k], e.stall);
        chk("stall_ID",    e.k, e.cyc, a_sid[e.k], e.stall);
        chk("bubble_EX",   e.k, e.cyc, a_bub[e.k], e.stall);
        chk("flush_IF",    e.k, e.cyc, a_fif[e.k], e.flush);
        chk("flush_ID",    e.k, e.cyc, a_fid[e.k], e.flush);
        chk("busy_mask",   e.k, e.cyc, a_bm[e.k],  e.bm);
        chk("stall_count", e.k, e.cyc, a_sc[e.k],  e.sc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: state is unknown before the first edge, so the first cycle is
    // not checked; the following ones check the reset state.
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_en = 1'b1;
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use: lw x5 ; add x6,x5,x0 held in ID
    ins(0, 0, 0, 0, 5, 1, 1, 0);
    repeat (4) ins(5, 1, 0, 1, 6, 1, 0, 0);
    nops(4);

    // ALU write to x8, consumer two instructions later
    ins(0, 0, 0, 0, 8, 1, 0, 0);
    ins(1, 1, 2, 1, 10, 1, 0, 0);
    repeat (2) ins(8, 1, 0, 0, 11, 1, 0, 0);
    nops(4);

    // x0 never tracked; unused rs2 pointing at a busy register
    ins(0, 0, 0, 0, 0, 1, 1, 0);
    nops(1);
    ins(0, 0, 0, 0, 5, 1, 1, 0);
    repeat (2) ins(3, 1, 5, 0, 12, 1, 0, 0);
    nops(4);

    // WAW: load x9 then ALU write x9, then a consumer of x9
    ins(0, 0, 0, 0, 9, 1, 1, 0);
    ins(1, 1, 0, 0, 9, 1, 0, 0);
    repeat (5) ins(4, 1, 9, 1, 13, 1, 0, 0);
    nops(4);

    // Flush during a stall
    ins(0, 0, 0, 0, 5, 1, 1, 0);
    ins(5, 1, 0, 0, 14, 1, 0, 0);
    ins(5, 1, 0, 0, 14, 1, 0, 1);
    nops(4);

    // Reset mid-stall, then the held consumer issues without stalling
    ins(0, 0, 0, 0, 5, 1, 1, 0);
    ins(5, 1, 0, 0, 15, 1, 0, 0);
    step(1'b0, 1'b1, 5, 1, 0, 0, 15, 1, 0, 0);
    repeat (2) ins(5, 1, 0, 0, 15, 1, 0, 0);
    nops(3);

    // Repeated load-use pairs to drive the 4-bit counter into saturation
    repeat (8) begin
      ins(0, 0, 0, 0, 7, 1, 1, 0);
      repeat (4) ins(7, 1, 7, 0, 16, 1, 0, 0);
    end
    nops(2);

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      bit r_n, v, u1, u2, we, ld, fl;
      int rs1, rs2, rd;
      r_n = ($urandom_range(0, 199) != 0);
      v   = ($urandom_range(0, 7) != 0);
      rs1 = ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      u1  = $urandom_range(0, 1);
      u2  = $urandom_range(0, 1);
      rd  = $urandom_range(0, 7);
      we  = ($urandom_range(0, 3) != 0);
      ld  = we && ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 15) == 0);
      step(r_n, v, rs1, u1, rs2, u2, rd, we, ld, fl);
    end
    nops(2);

    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
